pipo_share_ctrl: RTL and testbench

Round-robin controller that shares one WIDTH-bit parallel-in/parallel-out storage register among NREQ requesters. Each requester presents a data word with a request. The controller picks one winner per transfer, loads the winner's word into the internal storage register, and acknowledges the winner. The register contents and the owning requester ID are always visible on the outputs. The block sits between several producer blocks and the shared buffer register, and it contains that register.

---
 rtl/pipo_share_ctrl.sv | 80 ++++++++
 tb/tb_pipo_share_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pipo_share_ctrl.sv
// pipo_share_ctrl: round-robin arbiter that loads one requester word per transfer into a shared storage register
module pipo_share_ctrl #(
    parameter  int NREQ  = 4,
    parameter  int WIDTH = 4,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] wdata,
    input  logic                  clr,
    output logic [NREQ-1:0]       grant,
    output logic [NREQ-1:0]       ack,
    output logic [WIDTH-1:0]      dataout,
    output logic [IDW-1:0]        owner,
    output logic                  valid,
    output logic                  busy
);
    typedef enum logic [1:0] {IDLE, LOAD, ACK} state_t;
    state_t         state, nxt;
    logic [IDW-1:0] win, last, pick, idx;
    logic [NREQ-1:0] win_oh;

    // first asserted request after the previous winner, wrapping modulo NREQ
    always_comb begin
        pick = '0;
        idx  = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = IDW'((int'(last) + k) % NREQ);
            if (req[idx]) pick = idx;
        end
    end

    // transfer sequencing; a pending clear in IDLE holds off arbitration
    always_comb begin
        nxt = (state == IDLE) ? ((!clr && |req) ? LOAD : IDLE) :
              (state == LOAD) ? ACK : IDLE;
    end

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nxt;
    end

    // winner capture, storage register load/clear and round-robin pointer update
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            win     <= '0;
            last    <= IDW'(NREQ - 1);
            dataout <= '0;
            owner   <= '0;
            valid   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (clr) begin
                        dataout <= '0;
                        owner   <= '0;
                        valid   <= 1'b0;
                    end else if (|req) begin
                        win <= pick;
                    end
                end
                LOAD: begin
                    dataout <= wdata[int'(win)*WIDTH +: WIDTH];
                    owner   <= win;
                    valid   <= 1'b1;
                end
                ACK:     last <= win;
                default: ;
            endcase
        end
    end

    assign win_oh = {{(NREQ-1){1'b0}}, 1'b1} << win;
    assign grant  = (state == LOAD) ? win_oh : '0;
    assign ack    = (state == ACK)  ? win_oh : '0;
    assign busy   = (state != IDLE);
endmodule

// File: tb/tb_pipo_share_ctrl.sv
// tb_pipo_share_ctrl: scoreboard bench for the shared storage register controller
module tb_pipo_share_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clr = 1'b0;
    logic [3:0]  req = '0;
    logic [15:0] wdata = '0;
    logic [3:0]  grant, ack, dataout;
    logic [1:0]  owner;
    logic        valid, busy;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] d;
        logic [1:0] o;
    } exp_t;

    exp_t q[$];
    int errors = 0;
    int checks = 0;
    int cyc = 0;

    pipo_share_ctrl #(.NREQ(4), .WIDTH(4)) dut (
        .clk(clk), .reset(reset), .req(req), .wdata(wdata), .clr(clr),
        .grant(grant), .ack(ack), .dataout(dataout), .owner(owner),
        .valid(valid), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input int id, input logic [3:0] d);
        exp_t e;
        e.a = 4'(1 << id);
        e.d = d;
        e.o = 2'(id);
        q.push_back(e);
    endtask

    task automatic wait_ack(output int c);
        c = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ack != 0) begin
                c = cyc;
                break;
            end
        end
        check("ack_seen", int'(c >= 0), 1);
    endtask

    // scoreboard: every ack must match the oldest expected transfer
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            check("excl", int'(grant & ack), 0);
            if (ack != 0) begin
                if (q.size() == 0) check("unexp_ack", int'(ack), 0);
                else begin
                    e = q.pop_front();
                    check("sb_ack", int'(ack), int'(e.a));
                    check("sb_data", int'(dataout), int'(e.d));
                    check("sb_owner", int'(owner), int'(e.o));
                    check("sb_valid", int'(valid), 1);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int c, prev;
        req   = 4'($urandom);
        wdata = 16'($urandom);
        clr   = 1'($urandom);
        repeat (3) @(negedge clk);
        check("rst_grant", int'(grant), 0);
        check("rst_ack", int'(ack), 0);
        check("rst_data", int'(dataout), 0);
        check("rst_owner", int'(owner), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_busy", int'(busy), 0);
        req = '0;
        clr = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rel_data", int'(dataout), 0);
        check("rel_valid", int'(valid), 0);
        check("rel_busy", int'(busy), 0);
        req = 4'b0100;
        wdata = 16'h0A00;
        push(2, 4'hA);
        @(negedge clk);
        check("single_grant", int'(grant), 4'b0100);
        check("single_busy", int'(busy), 1);
        check("single_noack", int'(ack), 0);
        req = '0;
        @(negedge clk);
        check("single_ack", int'(ack), 4'b0100);
        check("single_nogrant", int'(grant), 0);
        @(negedge clk);
        check("single_idle", int'(busy), 0);
        check("single_data_hold", int'(dataout), 4'hA);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        req = 4'hF;
        wdata = 16'h4321;
        push(0, 4'h1); push(1, 4'h2); push(2, 4'h3); push(3, 4'h4); push(0, 4'h1);
        prev = 0;
        for (int i = 0; i < 5; i++) begin
            wait_ack(c);
            if (i > 0) check("rr_gap", c - prev, 3);
            prev = c;
        end
        req = '0;
        req = 4'b1000;
        wdata = 16'h7000;
        push(3, 4'h7);
        wait_ack(c);
        req = '0;
        @(negedge clk);
        req = 4'b1001;
        wdata = 16'h6005;
        push(0, 4'h5);
        push(3, 4'h6);
        wait_ack(c);
        wait_ack(c);
        req = '0;
        req = 4'b0010;
        wdata = 16'h00C0;
        push(1, 4'hC);
        wait_ack(c);
        req = '0;
        @(negedge clk);
        clr = 1'b1;
        req = 4'b0010;
        wdata = 16'h0090;
        @(negedge clk);
        check("clr_data", int'(dataout), 0);
        check("clr_valid", int'(valid), 0);
        check("clr_owner", int'(owner), 0);
        check("clr_busy", int'(busy), 0);
        clr = 1'b0;
        push(1, 4'h9);
        @(negedge clk);
        check("clr_grant", int'(grant), 4'b0010);
        clr = 1'b1;
        @(negedge clk);
        check("clr_ack", int'(ack), 4'b0010);
        check("clr_in_load", int'(dataout), 4'h9);
        clr = 1'b0;
        req = '0;
        @(negedge clk);
        req = 4'b0001;
        wdata = 16'h0002;
        push(0, 4'hE);
        @(negedge clk);
        check("drop_grant", int'(grant), 4'b0001);
        req = '0;
        wdata = 16'h000E;
        @(negedge clk);
        check("drop_ack", int'(ack), 4'b0001);
        check("late_wdata", int'(dataout), 4'hE);
        @(negedge clk);
        req = 4'b0100;
        wdata = 16'h0B00;
        push(2, 4'hB);
        wait_ack(c);
        #2 reset = 1'b0;
        #1;
        check("ra_ack", int'(ack), 0);
        check("ra_grant", int'(grant), 0);
        check("ra_data", int'(dataout), 0);
        check("ra_owner", int'(owner), 0);
        check("ra_valid", int'(valid), 0);
        check("ra_busy", int'(busy), 0);
        req = '0;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_rst_ack", int'(ack), 0);
        end
        check("q_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
